// File: rtl/bnn_layer_seq.sv
// rtl/bnn_layer_seq.sv - time-multiplexed binary neural network layer, one neuron per clock
module bnn_layer_seq #(
  parameter int N_IN  = 16,
  parameter int N_OUT = 8,
  localparam int CW = $clog2(N_IN + 1),
  localparam int AW = (N_OUT > 1) ? $clog2(N_OUT) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_en,
  output logic             wr_ready,
  input  logic [AW-1:0]    wr_addr,
  input  logic [N_IN-1:0]  wr_weight,
  input  logic [CW-1:0]    wr_thresh,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [N_IN-1:0]  in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [N_OUT-1:0] out_data,
  output logic             busy
);

  typedef enum logic [1:0] {IDLE, COMPUTE, DONE} state_t;

  localparam logic [AW:0]   N_OUT_W = N_OUT[AW:0];
  localparam logic [AW-1:0] LAST    = AW'(N_OUT - 1);

  state_t state, state_nxt;

  logic [N_IN-1:0] w_mem [N_OUT];
  logic [CW-1:0]   t_mem [N_OUT];
  logic [N_IN-1:0] x_reg;
  logic [AW-1:0]   cnt;

  logic            accept;
  logic            done_hs;
  logic            last;
  logic            wr_ok;
  logic [N_IN-1:0] match;
  logic [CW-1:0]   pc;
  logic            bit_k;

  assign in_ready = (state == IDLE);
  assign wr_ready = (state == IDLE);
  assign busy     = (state != IDLE);

  assign accept  = in_valid && in_ready;
  assign done_hs = out_valid && out_ready && (state == DONE);
  assign last    = (cnt == LAST);
  assign wr_ok   = wr_en && wr_ready && ({1'b0, wr_addr} < N_OUT_W);

  // XNOR-popcount of the captured vector against the row selected by the neuron counter
  always_comb begin
    match = ~(x_reg ^ w_mem[cnt]);
    pc    = '0;
    for (int i = 0; i < N_IN; i++) begin
      pc = pc + CW'(match[i]);
    end
    bit_k = (pc >= t_mem[cnt]);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = COMPUTE;
      COMPUTE: if (last) state_nxt = DONE;
      DONE:    if (done_hs) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Writes land in the same edge as an accept, so the new weights apply to that vector
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int k = 0; k < N_OUT; k++) begin
        w_mem[k] <= '0;
        t_mem[k] <= '0;
      end
      x_reg     <= '0;
      cnt       <= '0;
      out_data  <= '0;
      out_valid <= 1'b0;
    end else begin
      if (wr_ok) begin
        w_mem[wr_addr] <= wr_weight;
        t_mem[wr_addr] <= wr_thresh;
      end
      if (accept) begin
        x_reg    <= in_data;
        cnt      <= '0;
        out_data <= '0;
      end
      if (state == COMPUTE) begin
        out_data[cnt] <= bit_k;
        cnt           <= last ? '0 : cnt + 1'b1;
      end
      if (state == COMPUTE && last) begin
        out_valid <= 1'b1;
      end else if (done_hs) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: doc/bnn_layer_seq.md
Name: bnn_layer_seq

Overview:
Parametrised, time-multiplexed binary neural network (BNN) layer; successor to the fixed 4-input/4-neuron combinational MLP.
- Each neuron computes popcount(XNOR(input, weight row)) and compares it against a per-neuron threshold.
- One neuron is evaluated per clock. Weights and thresholds live in internal registers loaded through a write port.
- Input vectors and result vectors move over valid/ready handshakes, so the layer sits between the SPI register bank and the downstream layer or readout logic.

Parameters:
N_IN, 16, input vector width (bits per neuron weight row), >=2
N_OUT, 8, number of neurons (output vector width), >=1
CW, $clog2(N_IN+1), derived (localparam); popcount/threshold width
AW, $clog2(N_OUT) (min 1), derived (localparam); neuron address width

Ports:
clk  in  1  single clock
rst_n  in  1  synchronous active-low reset
wr_en  in  1  write weight row + threshold for neuron wr_addr
wr_ready  out  1  write port accepts (high only in IDLE)
wr_addr  in  AW  neuron index
wr_weight  in  N_IN  weight row
wr_thresh  in  CW  threshold
in_valid  in  1  input vector valid
in_ready  out  1  layer can accept input
in_data  in  N_IN  binary input vector
out_valid  out  1  result valid
out_ready  in  1  consumer accepts result
out_data  out  N_OUT  result vector; bit k = neuron k
busy  out  1  high in COMPUTE or DONE

Behaviour:
- Reset (rst_n=0 at a clk edge) forces:
  - state=IDLE; all weight rows=0, all thresholds=0; captured input=0; neuron counter=0.
  - out_data=0, out_valid=0, busy=0; in_ready=1 and wr_ready=1 once in IDLE.
  - Reset mid-operation abandons the vector; no partial result is ever presented.
- States:
  - IDLE: in_ready=1, wr_ready=1.
    - Write: wr_en=1 writes the row/threshold at the edge; wr_addr>=N_OUT is ignored.
    - Input: in_valid&&in_ready captures in_data, clears the result register and counter, and moves to COMPUTE.
    - Simultaneous wr_en and input accept: the write commits first, so the new weights apply to that vector.
  - COMPUTE: lasts exactly N_OUT cycles; cycle k (k=0..N_OUT-1) evaluates neuron k and registers bit k.
    - bit_k = (popcount(~(x ^ W[k])) >= T[k]), unsigned compare in CW bits.
    - T[k]=0 gives bit=1 always. T[k]>N_IN (possible when N_IN+1 is not a power of two) gives bit=0 always.
    - After neuron N_OUT-1, go to DONE.
  - DONE: out_valid=1, out_data stable; in_ready=0, wr_ready=0.
    - Handshake out_valid&&out_ready: next cycle state=IDLE and out_valid=0.
    - out_data keeps its last value until the next input is accepted.
- Writes outside IDLE:
  - wr_ready=0; any wr_en is dropped with no side effect.
  - An in-flight vector always uses the weights present at accept time.
- in_valid outside IDLE is ignored (in_ready=0).
- Latency: accept at edge t gives out_valid=1 after edge t+N_OUT.
  - out_valid is visible in the cycle following edge t+N_OUT, i.e. N_OUT+1 cycles after the accept cycle.
  - Throughput: one vector per N_OUT+2 cycles with out_ready held high (includes one IDLE bubble).
- Popcount is combinational over N_IN bits within one cycle; no multi-cycle paths.
- All outputs are registered except in_ready, wr_ready and busy, which are decoded from state.

Test Plan:
1. Reset, N_IN=4/N_OUT=4: hold rst_n=0 for 2 cycles -> out_valid=0, out_data=0, busy=0, in_ready=1, wr_ready=1. Then input 4'b1011 with no writes -> out_data=4'b1111 (all T=0).
2. Functional: write W0=1010/T0=3, W1=1111/T1=4, W2=0000/T2=0, W3=0101/T3=4, then input 1010.
   - Response: out_data=4'b0101 (bit0=1, bit2=1).
   - Timing: out_valid first high exactly 5 cycles after the accept cycle.
3. Backpressure: hold out_ready=0 for 10 cycles in DONE -> out_valid and out_data stable, in_ready=0. Then out_ready=1 -> out_valid=0 next cycle, then in_ready=1.
4. Write during COMPUTE: with case-2 weights, pulse wr_en (addr 0, W=0000, T=4) at COMPUTE cycle 1 -> wr_ready=0, result still 4'b0101. Re-run the same input -> still 4'b0101.
5. Reset mid-COMPUTE: assert rst_n=0 at COMPUTE cycle 2 -> next cycle out_valid=0, busy=0, in_ready=1. Next input 0000 -> out_data=4'b1111 (weights cleared).
6. Threshold bounds, N_IN=4: T=4 with full match (W=x=1100) -> bit=1; T=5 -> bit=0. Also N_IN=5 (CW=3): T=7 -> bit=0; wr_addr=4 with N_OUT=4 is ignored.
